// File: rtl/opb_register_simulink2ppc_snap.sv
// OPB slave that hands 32-bit words captured from user logic to PPC software.
// Optional per-capture cycle timestamp at offset 0xC: define SIMULINK2PPC_TIMESTAMP_EN.
module opb_register_simulink2ppc_snap #(
    parameter logic [31:0] C_BASEADDR   = 32'hFFFF_FFFF,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_0000,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter string       C_FAMILY     = "virtex5"
) (
    input  logic        OPB_Clk,
    input  logic        OPB_Rst,
    input  logic [0:31] OPB_ABus,
    input  logic [0:3]  OPB_BE,
    input  logic [0:31] OPB_DBus,
    input  logic        OPB_RNW,
    input  logic        OPB_select,
    input  logic        OPB_seqAddr,
    output logic [0:31] Sl_DBus,
    output logic        Sl_xferAck,
    output logic        Sl_errAck,
    output logic        Sl_retry,
    output logic        Sl_toutSup,
    input  logic [31:0] user_data_in,
    input  logic        user_valid_in,
    output logic        user_ack_out
);

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;
    localparam logic [1:0] OFF_TS     = 2'd3;

    generate
        if ((C_OPB_AWIDTH != 32) || (C_OPB_DWIDTH != 32) || (C_FAMILY == "")) begin : g_bad_config
            $error("opb_register_simulink2ppc_snap supports only a 32-bit OPB");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [1:0]  off_r;
    logic        rnw_r;
    logic [31:0] data_r;
    logic        valid_r;
    logic        armed_r;
    logic [7:0]  ovf_r;
    logic        uack_r;
    logic        xack_r;
    logic [31:0] rdata_r;

    logic        hit_s;
    logic        rd_data_s;
    logic        ctrl_wr_s;
    logic        clear_s;
    logic        strobe_s;
    logic        accept_s;
    logic [31:0] data_nxt_s;
    logic        valid_nxt_s;
    logic        armed_nxt_s;
    logic [7:0]  ovf_nxt_s;
    logic [31:0] ts_word_s;
    logic [31:0] rd_word_s;
    logic        unused_s;

    assign unused_s = ^{OPB_seqAddr, OPB_DBus[0:29]};

    // Address decode and bus events of the current cycle
    always_comb begin
        hit_s     = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
        rd_data_s = (state_r == ACK) && rnw_r && (off_r == OFF_DATA);
        ctrl_wr_s = (state_r == ACK) && !rnw_r && (off_r == OFF_CTRL) && (|OPB_BE);
        clear_s   = ctrl_wr_s && OPB_DBus[30];
        strobe_s  = armed_r && user_valid_in;
    end

    // Bus handshake next state: one ack per select assertion
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (hit_s) begin
                    state_nxt_s = ACK;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACK: state_nxt_s = HOLD;
            HOLD: begin
                if (!OPB_select) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Capture, overflow and control updates; clear beats a same-edge capture
    always_comb begin
        data_nxt_s  = data_r;
        valid_nxt_s = valid_r;
        ovf_nxt_s   = ovf_r;
        armed_nxt_s = armed_r;
        accept_s    = 1'b0;
        if (clear_s) begin
            valid_nxt_s = 1'b0;
            ovf_nxt_s   = 8'd0;
        end else if (strobe_s && (!valid_r || rd_data_s)) begin
            // a DATA read on this edge frees the slot for the new sample
            data_nxt_s  = user_data_in;
            valid_nxt_s = 1'b1;
            accept_s    = 1'b1;
        end else if (strobe_s) begin
            if (ovf_r != 8'hFF) begin
                ovf_nxt_s = ovf_r + 8'd1;
            end else begin
                ovf_nxt_s = ovf_r;
            end
        end else if (rd_data_s) begin
            valid_nxt_s = 1'b0;
        end else begin
            valid_nxt_s = valid_r;
        end
        if (ctrl_wr_s) begin
            armed_nxt_s = OPB_DBus[31];
        end else begin
            armed_nxt_s = armed_r;
        end
    end

`ifdef SIMULINK2PPC_TIMESTAMP_EN
    logic [31:0] cnt_r;
    logic [31:0] ts_r;
    logic [31:0] ts_nxt_s;

    // Timestamp follows the same clear/capture priority as the data word
    always_comb begin
        if (clear_s) begin
            ts_nxt_s = 32'd0;
        end else if (accept_s) begin
            ts_nxt_s = cnt_r;
        end else begin
            ts_nxt_s = ts_r;
        end
    end

    // Free-running cycle counter and timestamp register
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            cnt_r <= 32'd0;
            ts_r  <= 32'd0;
        end else begin
            cnt_r <= cnt_r + 32'd1;
            ts_r  <= ts_nxt_s;
        end
    end

    assign ts_word_s = ts_nxt_s;
`else
    assign ts_word_s = 32'd0;
`endif

    // Read word as it will stand during the ack cycle
    always_comb begin
        case (OPB_ABus[28:29])
            OFF_DATA:   rd_word_s = data_nxt_s;
            OFF_STATUS: rd_word_s = {15'd0, armed_nxt_s, ovf_nxt_s, 7'd0, valid_nxt_s};
            OFF_CTRL:   rd_word_s = 32'd0;
            OFF_TS:     rd_word_s = ts_word_s;
            default:    rd_word_s = 32'd0;
        endcase
    end

    // Handshake state, latched request and registered bus outputs
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state_r <= IDLE;
            off_r   <= 2'd0;
            rnw_r   <= 1'b0;
            xack_r  <= 1'b0;
            rdata_r <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == IDLE) && hit_s) begin
                off_r <= OPB_ABus[28:29];
                rnw_r <= OPB_RNW;
            end
            xack_r  <= (state_nxt_s == ACK);
            rdata_r <= (state_nxt_s == ACK) ? rd_word_s : 32'd0;
        end
    end

    // Captured word, status fields and user acknowledge
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            data_r  <= 32'd0;
            valid_r <= 1'b0;
            armed_r <= 1'b0;
            ovf_r   <= 8'd0;
            uack_r  <= 1'b0;
        end else begin
            data_r  <= data_nxt_s;
            valid_r <= valid_nxt_s;
            armed_r <= armed_nxt_s;
            ovf_r   <= ovf_nxt_s;
            uack_r  <= accept_s;
        end
    end

    assign Sl_DBus      = rdata_r;
    assign Sl_xferAck   = xack_r;
    assign Sl_errAck    = 1'b0;
    assign Sl_retry     = 1'b0;
    assign Sl_toutSup   = 1'b0;
    assign user_ack_out = uack_r;

endmodule

// File: doc/opb_register_simulink2ppc_snap.md
Name: opb_register_simulink2ppc_snap

Overview:
- OPB slave that carries data in the fabric-to-processor direction: user logic pushes 32-bit words, PPC software reads them over OPB.
- Captures a value from the user side under a valid strobe and holds it until software reads it.
- Software sees a status word with a valid flag and a saturating overflow count, and arms or clears the block through a control word.
- Sits on the same OPB bus as the existing software-to-user registers; single clock domain (OPB_Clk).

Parameters:
- C_BASEADDR, 32'hFFFFFFFF, first byte address of the 4-word register window.
- C_HIGHADDR, 32'h00000000, last byte address of the window (must span at least 16 bytes).
- C_OPB_AWIDTH, 32, OPB address width.
- C_OPB_DWIDTH, 32, OPB data width.
- C_FAMILY, "virtex5", target family string (informational).

Ports:
- OPB_Clk  in  1  sole clock, all logic rising-edge.
- OPB_Rst  in  1  synchronous, active-high reset.
- OPB_ABus  in  [0:31]  OPB address, bit 0 = MSB.
- OPB_BE  in  [0:3]  byte enables.
- OPB_DBus  in  [0:31]  write data.
- OPB_RNW  in  1  1 = read, 0 = write.
- OPB_select  in  1  transfer in progress.
- OPB_seqAddr  in  1  ignored.
- Sl_DBus  out  [0:31]  read data; zero whenever Sl_xferAck=0.
- Sl_xferAck  out  1  one-cycle transfer acknowledge.
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  constant 0.
- user_data_in  in  [31:0]  value to capture.
- user_valid_in  in  1  capture strobe, sampled every cycle.
- user_ack_out  out  1  one-cycle pulse, the cycle after an accepted capture.

Behaviour:
- Reset (OPB_Rst=1 at a clock edge):
  - All outputs go to 0.
  - valid=0, armed=0, overflow=0, data=0; FSM=IDLE.
  - Reset mid-transaction aborts the transfer; no Sl_xferAck is issued for it.
- Address hit: OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR. Word offset = OPB_ABus[28:29].
- Register map:
  - 0x0 DATA: RO, captured word.
  - 0x4 STATUS: RO. Bit0 = valid, bits[15:8] = overflow (saturates at 255), bit16 = armed, other bits 0. Numbering is LSB=0 on the mapped 32-bit word, i.e. STATUS[0] = Sl_DBus[31].
  - 0x8 CONTROL: WO, reads 0. Bit0 = arm (level, stored). Bit1 = clear (self-clearing pulse: valid<=0, overflow<=0).
  - 0xC TIMESTAMP: see Optional Feature.
- OPB FSM, states IDLE, ACK, HOLD:
  - IDLE -> ACK when a hit is sampled.
  - ACK: Sl_xferAck=1 for exactly one cycle, Sl_DBus driven with the selected word. A write takes effect at this edge only if any OPB_BE bit is 1. Go to HOLD.
  - HOLD -> IDLE when OPB_select=0.
  - Latency: ack exactly 1 cycle after the hit is sampled; at most one ack per select assertion.
  - Writes to RO offsets are acked and ignored.
- Capture, evaluated every cycle when armed=1 and user_valid_in=1:
  - valid=0: data<=user_data_in, valid<=1, user_ack_out=1 next cycle.
  - valid=1: data unchanged (first sample held), overflow<=min(overflow+1, 255), no user_ack_out.
  - armed=0: strobe ignored, nothing counted.
- DATA read (ACK cycle at offset 0x0): returns the current data; valid<=0 at that edge.
- Simultaneous events, same edge:
  - DATA read + capture: read returns the old data; the new sample is stored; valid stays 1; not counted as overflow.
  - Clear + capture: clear wins; sample discarded; overflow=0; no user_ack_out.
  - CONTROL arm=0 write + strobe: the strobe is still evaluated with the pre-write armed value.
- Overflow saturates at 255 and never wraps.

Optional Feature:
- Macro: SIMULINK2PPC_TIMESTAMP_EN.
- Defined:
  - 32-bit free-running cycle counter, reset to 0, wraps at 2^32.
  - Counter value is latched into a timestamp register on every accepted capture (same edge as data).
  - 0x0C reads the timestamp register.
  - Clear resets the timestamp register, not the counter.
- Undefined: no counter or timestamp register; 0x0C reads 0.

Test Plan:
- Reset, then read 0x4 -> Sl_DBus=0; ack exactly 1 cycle after select; Sl_DBus=0 outside the ack cycle.
- Write 0x8=1, pulse user_valid_in with 0xDEADBEEF -> user_ack_out pulses next cycle; read 0x4=0x00010001; read 0x0=0xDEADBEEF; read 0x4=0x00010000.
- Armed, capture 0x11111111, then 300 further strobes -> 0x0 reads 0x11111111; 0x4 overflow field=0xFF (saturated).
- DATA read ack and strobe 0x22222222 on the same edge -> read returns the old word; valid=1; next read of 0x0=0x22222222; overflow unchanged.
- Clear write coincident with a strobe -> 0x4=0x00010000 (no valid, overflow 0); no user_ack_out. Separately, assert OPB_Rst during HOLD -> no ack; all registers read 0 afterwards.
- With SIMULINK2PPC_TIMESTAMP_EN: capture at counter 1000 -> 0xC reads 1000. Without the macro: 0xC reads 0.
